alu_result_fifo: RTL and testbench

Registered result buffer that sits directly downstream of the 4-bit ALU (`alu_4bit`). It captures each ALU result (`Y`, `carry`) together with the opcode (`sel`) that produced it, derives a zero flag, and holds up to DEPTH entries in a first-word-fall-through FIFO. Entries are presented to the consumer through a valid/ready handshake. Overflow attempts are dropped and reported.

---
 rtl/alu_result_fifo_if.sv | 31 +++
 rtl/alu_result_fifo.sv | 91 +++++++++
 tb/tb_alu_result_fifo.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_fifo_if.sv
// Handshake and status bundle between the ALU result FIFO and its producer/consumer.
// master is the FIFO's view; slave is the view of the logic around it.
interface alu_result_fifo_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_sel;
    logic [WIDTH-1:0]         in_y;
    logic                     in_carry;
    logic                     out_valid;
    logic                     out_ready;
    logic [2:0]               out_sel;
    logic [WIDTH-1:0]         out_y;
    logic                     out_carry;
    logic                     out_zero;
    logic [$clog2(DEPTH):0]   count;
    logic                     ovf;
    logic [7:0]               drop_cnt;

    modport master (
        input  in_valid, in_sel, in_y, in_carry, out_ready,
        output in_ready, out_valid, out_sel, out_y, out_carry, out_zero, count, ovf, drop_cnt
    );

    modport slave (
        output in_valid, in_sel, in_y, in_carry, out_ready,
        input  in_ready, out_valid, out_sel, out_y, out_carry, out_zero, count, ovf, drop_cnt
    );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU results {sel, y, carry, zero} with a
// valid/ready handshake, sticky overflow flag and saturating drop counter.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_fifo_if.master    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 3 + WIDTH + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          full, empty, push, pop, drop;
    logic [EW-1:0] head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A pop in the same cycle never frees room for a push: in_ready is purely registered.
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;
    assign drop  = bus.in_valid && full;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hff) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; the zero flag is computed once, at write time.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {bus.in_sel, bus.in_y, bus.in_carry, (bus.in_y == '0)};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_sel   = head[EW-1 -: 3];
    assign bus.out_y     = head[WIDTH+1:2];
    assign bus.out_carry = head[1];
    assign bus.out_zero  = head[0];

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed and random checks of alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic [2:0]       sel;
        logic [WIDTH-1:0] y;
        logic             carry;
    } ent_t;

    logic clk;
    logic rst;

    alu_result_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t q[$];
    bit   m_ovf;
    int   m_drop;
    int   nvec;
    int   nerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        if (q.size() > 0) begin
            chk("out_sel", 32'(bus.out_sel), 32'(q[0].sel));
            chk("out_y", 32'(bus.out_y), 32'(q[0].y));
            chk("out_carry", 32'(bus.out_carry), 32'(q[0].carry));
            chk("out_zero", 32'(bus.out_zero), 32'(q[0].y == 0));
        end
    endtask

    // Check the present state, apply one clock with the given inputs, advance the model.
    task automatic step(input bit iv, input logic [2:0] s, input logic [WIDTH-1:0] y,
                        input bit c, input bit ordy);
        bit   full_now;
        ent_t e;
        bus.in_valid  = iv;
        bus.in_sel    = s;
        bus.in_y      = y;
        bus.in_carry  = c;
        bus.out_ready = ordy;
        check_outputs();
        @(posedge clk);
        full_now = (q.size() == DEPTH);
        if (ordy && q.size() > 0) void'(q.pop_front());
        if (iv && !full_now) begin
            e.sel = s;
            e.y = y;
            e.carry = c;
            q.push_back(e);
        end
        if (iv && full_now) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        #1;
    endtask

    task automatic do_reset(input bit iv, input bit ordy);
        rst           = 1'b1;
        bus.in_valid  = iv;
        bus.in_sel    = 3'd7;
        bus.in_y      = 4'hf;
        bus.in_carry  = 1'b1;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] ys [4];
        logic [WIDTH-1:0] yi;
        nvec = 0;
        nerr = 0;
        ys[0] = 4'b0010; ys[1] = 4'b0001; ys[2] = 4'b0111; ys[3] = 4'b0110;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_y = '0; bus.in_carry = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        do_reset(1'b0, 1'b0);

        // Single push, visible one cycle later.
        step(1'b1, 3'b000, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);

        // Fill, overflow once, drain in order.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), ys[i], 1'b0, 1'b0);
        step(1'b1, 3'b111, 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);

        // Zero and carry flags.
        step(1'b1, 3'b010, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 3'b001, 4'b1010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);

        // Sustained push+pop at count=2, wrapping the pointers.
        step(1'b1, 3'b011, 4'd1, 1'b0, 1'b0);
        step(1'b1, 3'b011, 4'd2, 1'b0, 1'b0);
        yi = 4'd3;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'(i), yi, 1'(i), 1'b1);
            yi = yi + 1'b1;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);

        // Full with push and pop together: pop wins, push dropped.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b100, ys[i], 1'b1, 1'b0);
        step(1'b1, 3'b101, 4'b1100, 1'b0, 1'b1);
        step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);

        // Reset mid-operation discards entries and ignores the reset-cycle handshake.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b110, ys[i], 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b1, 3'b101, 4'b1001, 1'b1, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);

        // Random traffic with varying producer/consumer pressure.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            bit iv;
            bit ordy;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(iv, 3'($urandom), 4'($urandom), 1'($urandom), ordy);
        end

        // Drive the drop counter into saturation.
        for (int i = 0; i < 4; i++) step(1'b1, 3'b001, 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 262; i++) step(1'b1, 3'b001, 4'd6, 1'b0, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
